fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 66 ++++++
 tb/tb_fetch_stage.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Fetch stage: PC register plus IF/ID pipeline register; instr_d follows imem_addr by one clock.
// No handshake: stall_f/stall_d hold state, flush_d inserts a NOP bubble, pc_src_e redirects the PC.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // A redirect wins over a front-end stall; the target is forced word-aligned.
  always_comb begin
    pc_next = pc_plus4;
    if (pc_src_e)
      pc_next = {pc_target_e[31:2], 2'b00};
    else if (stall_f)
      pc_next = pc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_PC;
      instr_d     <= NOP;
      pc_d        <= 32'd0;
      pc_plus4_d  <= 32'd0;
      valid_d     <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      pc <= pc_next;
      if (flush_d) begin
        instr_d    <= NOP;
        pc_d       <= 32'd0;
        pc_plus4_d <= 32'd0;
        valid_d    <= 1'b0;
      end else if (!stall_d) begin
        // The old PC is captured even if stall_f holds it, so a duplicate fetch is counted.
        instr_d     <= imem_rdata;
        pc_d        <= pc;
        pc_plus4_d  <= pc_plus4;
        valid_d     <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected pipeline state is queued as each cycle's stimulus is driven.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pcp4;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] imem_addr, imem_rdata, instr_d, pc_d, pc_plus4_d, fetch_count;
  logic        valid_d;
  logic [31:0] imem_addr2, imem_rdata2, instr_d2, pc_d2, pc_plus4_d2, fetch_count2;
  logic        valid_d2;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb_q[$];

  logic [31:0] m_pc, m_instr, m_pcd, m_pcp4, m_cnt;
  logic        m_valid;

  always #5 clk = ~clk;

  assign imem_rdata  = imem_addr ^ 32'hA5A5_0000;
  assign imem_rdata2 = imem_addr2 ^ 32'hA5A5_0000;

  fetch_stage u_dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .fetch_count(fetch_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .instr_d(instr_d2), .pc_d(pc_d2), .pc_plus4_d(pc_plus4_d2),
    .valid_d(valid_d2), .fetch_count(fetch_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, advance the reference model, and compare after the edge.
  task automatic step(input logic r, input logic sf, input logic sd, input logic fl,
                      input logic ps, input logic [31:0] tgt, input string tag);
    exp_t e, o;
    logic [31:0] nxt;
    rst = r; stall_f = sf; stall_d = sd; flush_d = fl; pc_src_e = ps; pc_target_e = tgt;
    if (!r) begin
      m_pc = 32'd0; m_instr = 32'h13; m_pcd = 0; m_pcp4 = 0; m_valid = 0; m_cnt = 0;
    end else begin
      nxt = ps ? {tgt[31:2], 2'b00} : (sf ? m_pc : m_pc + 32'd4);
      if (fl) begin
        m_instr = 32'h13; m_pcd = 0; m_pcp4 = 0; m_valid = 0;
      end else if (!sd) begin
        m_instr = m_pc ^ 32'hA5A5_0000; m_pcd = m_pc; m_pcp4 = m_pc + 32'd4;
        m_valid = 1; m_cnt = m_cnt + 1;
      end
      m_pc = nxt;
    end
    e.addr = m_pc; e.instr = m_instr; e.pcd = m_pcd; e.pcp4 = m_pcp4;
    e.valid = m_valid; e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".queue_empty"}, 32'd1, 32'd0);
    end else begin
      o = sb_q.pop_front();
      check({tag, ".imem_addr"},   imem_addr,   o.addr);
      check({tag, ".instr_d"},     instr_d,     o.instr);
      check({tag, ".pc_d"},        pc_d,        o.pcd);
      check({tag, ".pc_plus4_d"},  pc_plus4_d,  o.pcp4);
      check({tag, ".valid_d"},     {31'd0, valid_d}, {31'd0, o.valid});
      check({tag, ".fetch_count"}, fetch_count, o.cnt);
    end
  endtask

  initial begin
    logic sf, sd, fl, ps;
    rst = 0; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 0;
    #2;
    step(0, 0, 0, 0, 0, 0, "reset0");
    step(0, 1, 1, 1, 1, 32'h55, "reset1");
    step(1, 0, 0, 0, 0, 0, "first_fetch");
    check("wrap.pc_d",       pc_d2,       32'hFFFF_FFFC);
    check("wrap.pc_plus4_d", pc_plus4_d2, 32'h0000_0000);
    check("wrap.imem_addr",  imem_addr2,  32'h0000_0000);
    check("wrap.instr_d",    instr_d2,    32'h5A5A_FFFC);
    check("const.first_instr", instr_d,   32'hA5A5_0000);
    step(1, 0, 0, 0, 0, 0, "seq");
    step(1, 1, 1, 0, 0, 0, "stall_a");
    step(1, 1, 1, 0, 0, 0, "stall_b");
    check("const.stall_addr", imem_addr, 32'h8);
    step(1, 0, 0, 0, 0, 0, "stall_rel");
    check("const.stall_rel_pcd", pc_d, 32'h8);
    step(1, 0, 0, 0, 0, 0, "seq2");
    step(1, 0, 0, 1, 1, 32'h103, "redir_flush");
    check("const.redir_addr", imem_addr, 32'h100);
    step(1, 0, 0, 0, 0, 0, "after_redir");
    check("const.after_redir_pcd", pc_d, 32'h100);
    step(1, 1, 0, 0, 1, 32'h40, "redir_over_stall");
    step(1, 0, 1, 1, 0, 0, "flush_over_stall");
    step(1, 1, 0, 0, 0, 0, "dup_fetch_a");
    step(1, 1, 0, 0, 0, 0, "dup_fetch_b");
    step(1, 0, 0, 0, 1, 32'hFFFF_FFFF, "redir_top");
    step(1, 0, 0, 0, 0, 0, "wrap_fetch");
    for (int i = 0; i < 60; i++) begin
      sf = ($urandom_range(3) == 0);
      sd = ($urandom_range(3) == 0);
      fl = ($urandom_range(4) == 0);
      ps = ($urandom_range(5) == 0);
      step(1, sf, sd, fl, ps, $urandom, "rand");
    end
    step(0, 1, 0, 0, 1, 32'h200, "reset_mid_redir");
    step(1, 0, 0, 0, 0, 0, "post_reset");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
